axi_r_resp_router: RTL and testbench

- Return-path counterpart of the master-side request arbiter in the AXI interconnect.
- Collects read-data (R channel) beats from NUM_S slaves and routes each burst back to the originating master (M0 or M1), decoded from the upper ID nibble.
- Arbitrates round-robin among slaves with RVALID asserted and locks the winner until its RLAST handshake completes.
- Sits between the slave-side R channels and the two master-side R channels.

---
 rtl/axi_route_pkg.sv | 25 ++
 rtl/rr_pick.sv | 40 ++++
 rtl/axi_r_resp_router.sv | 160 ++++++++++++++++
 tb/tb_axi_r_resp_router.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_route_pkg.sv
// ============================================================================
// Module : axi_route_pkg
// Shared types and constants for the AXI response routers.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package axi_route_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam logic [3:0] MTAG_M0 = 4'h0;
  localparam logic [3:0] MTAG_M1 = 4'h1;

  localparam int IDS_W   = 8;
  localparam int IDM_W   = 4;
  localparam int DATA_W  = 32;
  localparam int RRESP_W = 2;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module : rr_pick
// Combinational round-robin selector; search starts one past i_ptr and wraps.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rr_pick
  import axi_route_pkg::*;
#(
  parameter int NUM_S = 3,
  parameter int PTR_W = (NUM_S > 1) ? $clog2(NUM_S) : 1
) (
  input  logic [NUM_S-1:0] i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [NUM_S-1:0] o_gnt,
  output logic [PTR_W-1:0] o_gnt_idx
);

  int   w_idx;
  logic w_found;

  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    w_found   = 1'b0;
    w_idx     = 0;
    for (int i = 1; i <= NUM_S; i++) begin
      w_idx = (int'(i_ptr) + i) % NUM_S;
      if (!w_found && (|(i_req & (NUM_S'(1) << w_idx)))) begin
        w_found   = 1'b1;
        o_gnt     = NUM_S'(1) << w_idx;
        o_gnt_idx = PTR_W'(w_idx);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/axi_r_resp_router.sv
// ============================================================================
// Module : axi_r_resp_router
// Routes slave R-channel bursts back to M0/M1 by RID tag, round-robin locked.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module axi_r_resp_router
  import axi_route_pkg::*;
#(
  parameter int NUM_S  = 3,
  parameter int IDS_W  = axi_route_pkg::IDS_W,
  parameter int DATA_W = axi_route_pkg::DATA_W
) (
  input  logic                      ACLK,
  input  logic                      ARESETn,
  input  logic [NUM_S*IDS_W-1:0]    RID_S,
  input  logic [NUM_S*DATA_W-1:0]   RDATA_S,
  input  logic [NUM_S*RRESP_W-1:0]  RRESP_S,
  input  logic [NUM_S-1:0]          RLAST_S,
  input  logic [NUM_S-1:0]          RVALID_S,
  output logic [NUM_S-1:0]          RREADY_S,
  output logic [IDM_W-1:0]          RID_M0,
  output logic [DATA_W-1:0]         RDATA_M0,
  output logic [RRESP_W-1:0]        RRESP_M0,
  output logic                      RLAST_M0,
  output logic                      RVALID_M0,
  input  logic                      RREADY_M0,
  output logic [IDM_W-1:0]          RID_M1,
  output logic [DATA_W-1:0]         RDATA_M1,
  output logic [RRESP_W-1:0]        RRESP_M1,
  output logic                      RLAST_M1,
  output logic                      RVALID_M1,
  input  logic                      RREADY_M1,
  output logic                      drop_err
);

  localparam int PTR_W = (NUM_S > 1) ? $clog2(NUM_S) : 1;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [PTR_W-1:0]   r_rr_ptr;
  logic [PTR_W-1:0]   r_gnt;
  logic               r_drop_err;

  logic [PTR_W-1:0]   w_pick_idx;
  logic [NUM_S-1:0]   w_pick_oh;
  logic [PTR_W-1:0]   w_sel_idx;
  logic [NUM_S-1:0]   w_sel_oh;
  logic               w_any;
  logic               w_has_gnt;

  logic [IDS_W-1:0]   w_sel_rid;
  logic [DATA_W-1:0]  w_sel_data;
  logic [RRESP_W-1:0] w_sel_resp;
  logic               w_sel_last;
  logic               w_sel_valid;

  logic [3:0]         w_tag;
  logic               w_to_m0;
  logic               w_to_m1;
  logic               w_drop;
  logic               w_ready;
  logic               w_hs;

  rr_pick #(
    .NUM_S (NUM_S),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .i_req     (RVALID_S),
    .i_ptr     (r_rr_ptr),
    .o_gnt     (w_pick_oh),
    .o_gnt_idx (w_pick_idx)
  );

  // In IDLE the live pick drives the mux so a first beat passes with no added latency.
  assign w_any     = |RVALID_S;
  assign w_has_gnt = ARESETn & ((r_state == BURST) | w_any);
  assign w_sel_idx = (r_state == IDLE) ? w_pick_idx : r_gnt;
  assign w_sel_oh  = (r_state == IDLE) ? w_pick_oh : (NUM_S'(1) << r_gnt);

  always_comb begin
    w_sel_rid   = '0;
    w_sel_data  = '0;
    w_sel_resp  = '0;
    w_sel_last  = 1'b0;
    w_sel_valid = 1'b0;
    for (int k = 0; k < NUM_S; k++) begin
      if (w_sel_idx == PTR_W'(k)) begin
        w_sel_rid   = RID_S[k*IDS_W +: IDS_W];
        w_sel_data  = RDATA_S[k*DATA_W +: DATA_W];
        w_sel_resp  = RRESP_S[k*RRESP_W +: RRESP_W];
        w_sel_last  = RLAST_S[k];
        w_sel_valid = RVALID_S[k];
      end
    end
  end

  // Unmapped tags are accepted unconditionally so a stray burst cannot stall the bus.
  assign w_tag   = w_sel_rid[IDM_W +: 4];
  assign w_to_m0 = (w_tag == MTAG_M0);
  assign w_to_m1 = (w_tag == MTAG_M1);
  assign w_drop  = ~w_to_m0 & ~w_to_m1;
  assign w_ready = w_to_m0 ? RREADY_M0 : (w_to_m1 ? RREADY_M1 : 1'b1);
  assign w_hs    = w_has_gnt & w_sel_valid & w_ready;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state    <= IDLE;
      r_rr_ptr   <= PTR_W'(NUM_S - 1);
      r_gnt      <= '0;
      r_drop_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_drop_err <= w_hs & w_drop;
      if ((r_state == IDLE) && w_any) begin
        r_gnt <= w_pick_idx;
      end
      if (w_hs && w_sel_last) begin
        r_rr_ptr <= w_sel_idx;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_any && !(w_hs && w_sel_last)) begin
          w_state_nxt = BURST;
        end
      end
      BURST: begin
        if (w_hs && w_sel_last) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    RVALID_M0 = w_has_gnt & w_to_m0 & w_sel_valid;
    RVALID_M1 = w_has_gnt & w_to_m1 & w_sel_valid;
    RREADY_S  = (w_has_gnt & w_ready) ? w_sel_oh : '0;
    RID_M0    = w_has_gnt ? w_sel_rid[IDM_W-1:0] : '0;
    RID_M1    = w_has_gnt ? w_sel_rid[IDM_W-1:0] : '0;
    RDATA_M0  = w_has_gnt ? w_sel_data : '0;
    RDATA_M1  = w_has_gnt ? w_sel_data : '0;
    RRESP_M0  = w_has_gnt ? w_sel_resp : '0;
    RRESP_M1  = w_has_gnt ? w_sel_resp : '0;
    RLAST_M0  = w_has_gnt & w_sel_last;
    RLAST_M1  = w_has_gnt & w_sel_last;
  end

  assign drop_err = r_drop_err;

endmodule

`default_nettype wire

// File: tb/tb_axi_r_resp_router.sv
// ============================================================================
// Module : tb_axi_r_resp_router
// Directed bench for axi_r_resp_router: routing, lock, fairness, sink, reset.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_axi_r_resp_router;

  logic        ACLK;
  logic        ARESETn;
  logic [23:0] RID_S;
  logic [95:0] RDATA_S;
  logic [5:0]  RRESP_S;
  logic [2:0]  RLAST_S;
  logic [2:0]  RVALID_S;
  logic [2:0]  RREADY_S;
  logic [3:0]  RID_M0,   RID_M1;
  logic [31:0] RDATA_M0, RDATA_M1;
  logic [1:0]  RRESP_M0, RRESP_M1;
  logic        RLAST_M0, RLAST_M1;
  logic        RVALID_M0, RVALID_M1;
  logic        RREADY_M0, RREADY_M1;
  logic        drop_err;

  int checks = 0;
  int errors = 0;

  axi_r_resp_router #(.NUM_S(3), .IDS_W(8), .DATA_W(32)) dut (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .RID_S     (RID_S),
    .RDATA_S   (RDATA_S),
    .RRESP_S   (RRESP_S),
    .RLAST_S   (RLAST_S),
    .RVALID_S  (RVALID_S),
    .RREADY_S  (RREADY_S),
    .RID_M0    (RID_M0),
    .RDATA_M0  (RDATA_M0),
    .RRESP_M0  (RRESP_M0),
    .RLAST_M0  (RLAST_M0),
    .RVALID_M0 (RVALID_M0),
    .RREADY_M0 (RREADY_M0),
    .RID_M1    (RID_M1),
    .RDATA_M1  (RDATA_M1),
    .RRESP_M1  (RRESP_M1),
    .RLAST_M1  (RLAST_M1),
    .RVALID_M1 (RVALID_M1),
    .RREADY_M1 (RREADY_M1),
    .drop_err  (drop_err)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic set_slave(input int k, input logic [7:0] id, input logic [31:0] data,
                           input logic last, input logic valid);
    RID_S[k*8 +: 8]    = id;
    RDATA_S[k*32 +: 32] = data;
    RRESP_S[k*2 +: 2]  = 2'b00;
    RLAST_S[k]         = last;
    RVALID_S[k]        = valid;
  endtask

  initial begin
    logic [2:0] exp_rr [4];
    int b;

    ARESETn = 1'b0;
    RID_S = '0; RDATA_S = '0; RRESP_S = '0; RLAST_S = '0; RVALID_S = '0;
    RREADY_M0 = 1'b0; RREADY_M1 = 1'b0;
    #1;
    chk("rst_rvalid_m0", RVALID_M0, 1'b0);
    chk("rst_rvalid_m1", RVALID_M1, 1'b0);
    chk("rst_rready_s",  RREADY_S, 3'b000);
    chk("rst_drop_err",  drop_err, 1'b0);
    tick(); tick();
    ARESETn = 1'b1;
    tick();
    chk("idle_rready_s", RREADY_S, 3'b000);

    // Single beat S1 -> M0, zero latency
    set_slave(1, 8'h03, 32'h0000_00A1, 1'b1, 1'b1);
    RREADY_M0 = 1'b1;
    #1;
    chk("single_rvalid_m0", RVALID_M0, 1'b1);
    chk("single_rid_m0",    RID_M0, 4'h3);
    chk("single_rdata_m0",  RDATA_M0, 32'h0000_00A1);
    chk("single_rvalid_m1", RVALID_M1, 1'b0);
    chk("single_rready_s",  RREADY_S, 3'b010);
    tick();
    RVALID_S[1] = 1'b0;

    // rr_ptr=1 and still IDLE: S2 beats S0 immediately
    set_slave(0, 8'h01, 32'h0000_00B0, 1'b1, 1'b1);
    set_slave(2, 8'h02, 32'h0000_00B2, 1'b1, 1'b1);
    #1;
    chk("ptr1_rready_s", RREADY_S, 3'b100);
    chk("ptr1_rid_m0",   RID_M0, 4'h2);
    tick();
    RVALID_S[2] = 1'b0;
    #1;
    chk("ptr2_rready_s", RREADY_S, 3'b001);
    tick();
    RVALID_S = '0;
    RREADY_M0 = 1'b0;

    // Burst lock: S0 4 beats to M1, S2 requests from beat 2
    RREADY_M1 = 1'b1;
    RREADY_M0 = 1'b1;
    set_slave(0, 8'h12, 32'h0000_0B00, 1'b0, 1'b1);
    #1;
    chk("lock_b0_rvalid_m1", RVALID_M1, 1'b1);
    chk("lock_b0_rvalid_m0", RVALID_M0, 1'b0);
    chk("lock_b0_rid_m1",    RID_M1, 4'h2);
    chk("lock_b0_rready_s",  RREADY_S, 3'b001);
    tick();
    set_slave(0, 8'h12, 32'h0000_0B01, 1'b0, 1'b1);
    set_slave(2, 8'h05, 32'h0000_0C00, 1'b1, 1'b1);
    #1;
    chk("lock_b1_rready_s", RREADY_S, 3'b001);
    chk("lock_b1_rdata_m1", RDATA_M1, 32'h0000_0B01);
    chk("lock_b1_rvalid_m0", RVALID_M0, 1'b0);
    tick();
    set_slave(0, 8'h12, 32'h0000_0B02, 1'b0, 1'b1);
    #1;
    chk("lock_b2_rready_s", RREADY_S, 3'b001);
    tick();
    set_slave(0, 8'h12, 32'h0000_0B03, 1'b1, 1'b1);
    #1;
    chk("lock_b3_rready_s", RREADY_S, 3'b001);
    chk("lock_b3_rlast_m1", RLAST_M1, 1'b1);
    tick();
    RVALID_S[0] = 1'b0;
    #1;
    chk("lock_s2_rready_s", RREADY_S, 3'b100);
    chk("lock_s2_rvalid_m0", RVALID_M0, 1'b1);
    chk("lock_s2_rid_m0",    RID_M0, 4'h5);
    tick();
    RVALID_S = '0;

    // Fairness: all valid, single beats; rr_ptr=2 -> S0,S1,S2,S0
    exp_rr[0] = 3'b001; exp_rr[1] = 3'b010; exp_rr[2] = 3'b100; exp_rr[3] = 3'b001;
    set_slave(0, 8'h01, 32'h0000_0D00, 1'b1, 1'b1);
    set_slave(1, 8'h02, 32'h0000_0D01, 1'b1, 1'b1);
    set_slave(2, 8'h03, 32'h0000_0D02, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr_%0d_rready_s", i), RREADY_S, exp_rr[i]);
      tick();
    end
    RVALID_S = '0;

    // Backpressure + gap: S1 4-beat to M0, S2 waiting for M1
    set_slave(2, 8'h1A, 32'h0000_0E00, 1'b1, 1'b1);
    b = 0;
    for (int c = 0; c < 12 && b < 4; c++) begin
      set_slave(1, 8'h07, 32'h0000_0C00 + b, (b == 3), (c != 4));
      RREADY_M0 = (c == 1 || c == 2) ? 1'b0 : 1'b1;
      #1;
      chk($sformatf("bp_c%0d_s2_blocked", c), RREADY_S[2], 1'b0);
      chk($sformatf("bp_c%0d_rvalid_m0", c), RVALID_M0, (c != 4));
      if (RVALID_M0 && RREADY_M0) begin
        chk($sformatf("bp_b%0d_rdata_m0", b), RDATA_M0, 32'h0000_0C00 + b);
        b++;
      end
      tick();
    end
    chk("bp_beat_count", b, 4);
    RVALID_S[1] = 1'b0;
    #1;
    chk("bp_s2_rready_s",  RREADY_S, 3'b100);
    chk("bp_s2_rvalid_m1", RVALID_M1, 1'b1);
    chk("bp_s2_rid_m1",    RID_M1, 4'hA);
    tick();
    RVALID_S = '0;

    // Unmapped tag on S2 is sunk even with both masters stalled
    RREADY_M0 = 1'b0;
    RREADY_M1 = 1'b0;
    set_slave(2, 8'h57, 32'h0000_0F00, 1'b1, 1'b1);
    #1;
    chk("drop_rvalid_m0", RVALID_M0, 1'b0);
    chk("drop_rvalid_m1", RVALID_M1, 1'b0);
    chk("drop_rready_s",  RREADY_S, 3'b100);
    chk("drop_err_pre",   drop_err, 1'b0);
    tick();
    RVALID_S[2] = 1'b0;
    RREADY_M0 = 1'b1;
    set_slave(0, 8'h04, 32'h0000_0F01, 1'b1, 1'b1);
    #1;
    chk("drop_err_pulse",  drop_err, 1'b1);
    chk("drop_next_rvalid_m0", RVALID_M0, 1'b1);
    chk("drop_next_rready_s",  RREADY_S, 3'b001);
    tick();
    RVALID_S = '0;
    chk("drop_err_clear", drop_err, 1'b0);

    // Reset mid-burst: S1 to M1, reset during beat 2
    RREADY_M1 = 1'b1;
    set_slave(1, 8'h11, 32'h0000_1000, 1'b0, 1'b1);
    #1;
    chk("rstb_b0_rready_s", RREADY_S, 3'b010);
    tick();
    set_slave(1, 8'h11, 32'h0000_1001, 1'b0, 1'b1);
    set_slave(0, 8'h02, 32'h0000_1100, 1'b1, 1'b1);
    #1;
    chk("rstb_b1_rready_s",  RREADY_S, 3'b010);
    chk("rstb_b1_rvalid_m1", RVALID_M1, 1'b1);
    ARESETn = 1'b0;
    #1;
    chk("rstb_rvalid_m0", RVALID_M0, 1'b0);
    chk("rstb_rvalid_m1", RVALID_M1, 1'b0);
    chk("rstb_rready_s",  RREADY_S, 3'b000);
    tick();
    ARESETn = 1'b1;
    #1;
    chk("rstb_post_rready_s",  RREADY_S, 3'b001);
    chk("rstb_post_rvalid_m0", RVALID_M0, 1'b1);
    chk("rstb_post_rvalid_m1", RVALID_M1, 1'b0);
    tick();
    RVALID_S = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
